// File: rtl/bus_ctrl.sv
// CPU data-port responder: DMEM, LED, 7-seg scan, cycle counter, status; reads are combinational, writes commit on the edge, no backpressure.
// Define BUS_CYCLE_CNT_EN to build the 32-bit cycle counter at 0xFFFF_0008.
module bus_ctrl #(
  parameter int DMEM_AW  = 6,
  parameter int SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_bc_addr,
  input  logic [31:0] cpu_bc_data,
  input  logic        cpu_bc_rw,
  output logic [31:0] bc_cpu_data,
  output logic [15:0] led,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam logic [29:0] LED_WA  = 30'h3FFF_C000;
  localparam logic [29:0] SEG_WA  = 30'h3FFF_C001;
  localparam logic [29:0] CYC_WA  = 30'h3FFF_C002;
  localparam logic [29:0] STAT_WA = 30'h3FFF_C003;
  localparam logic [14:0] DMEM_LIM = 15'(2**DMEM_AW);
  localparam logic [SCAN_DIV-1:0] SCAN_ONE = {{(SCAN_DIV-1){1'b0}}, 1'b1};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [29:0] word_addr;
  logic        unused_addr_lsb;
  logic        hit_dmem, hit_led, hit_seg, hit_cyc, hit_stat, hit_none;

  assign word_addr       = cpu_bc_addr[31:2];
  assign unused_addr_lsb = ^cpu_bc_addr[1:0];

  assign hit_dmem = (cpu_bc_addr[31:16] == 16'h0) && ({1'b0, cpu_bc_addr[15:2]} < DMEM_LIM);
  assign hit_led  = (word_addr == LED_WA);
  assign hit_seg  = (word_addr == SEG_WA);
  // Counter address stays "mapped" even when the counter is not built, so writes never flag.
  assign hit_cyc  = (word_addr == CYC_WA);
  assign hit_stat = (word_addr == STAT_WA);
  assign hit_none = !(hit_dmem || hit_led || hit_seg || hit_cyc || hit_stat);

  // Data RAM: no reset, contents survive rst.
  logic [31:0]        dmem_q [2**DMEM_AW];
  logic [DMEM_AW-1:0] dmem_idx;

  assign dmem_idx = cpu_bc_addr[DMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (cpu_bc_rw && hit_dmem) dmem_q[dmem_idx] <= cpu_bc_data;
  end

  logic [15:0] led_q, led_d;
  logic [15:0] segreg_q, segreg_d;
  logic        status_q, status_d;

  always_comb begin
    led_d    = led_q;
    segreg_d = segreg_q;
    status_d = status_q;
    if (cpu_bc_rw) begin
      if (hit_led) led_d = cpu_bc_data[15:0];
      if (hit_seg) segreg_d = cpu_bc_data[15:0];
      if (hit_none) status_d = 1'b1;
      else if (hit_stat && cpu_bc_data[0]) status_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q    <= 16'h0;
      segreg_q <= 16'h0;
      status_q <= 1'b0;
    end else begin
      led_q    <= led_d;
      segreg_q <= segreg_d;
      status_q <= status_d;
    end
  end

  logic [31:0] cyc_rd;

`ifdef BUS_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  // A write clears the counter and takes precedence over the increment.
  always_comb begin
    cyc_d = cyc_q + 32'd1;
    if (cpu_bc_rw && hit_cyc) cyc_d = 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= 32'h0;
    else     cyc_q <= cyc_d;
  end

  assign cyc_rd = cyc_q;
`else
  assign cyc_rd = 32'h0;
`endif

  logic [SCAN_DIV-1:0] scan_q, scan_d;
  logic [1:0]          sel;
  logic [3:0]          an_q, an_d;
  logic [7:0]          seg_q, seg_d;

  assign sel = scan_q[SCAN_DIV-1 -: 2];

  always_comb begin
    scan_d = scan_q + SCAN_ONE;
    an_d   = ~(4'b0001 << sel);
    seg_d  = {1'b1, hex7(segreg_q[{sel, 2'b00} +: 4])};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      an_q   <= 4'b1110;
      seg_q  <= 8'hC0;
    end else begin
      scan_q <= scan_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign led = led_q;
  assign an  = an_q;
  assign seg = seg_q;

  // Same-cycle read of a location being written returns the pre-edge value.
  always_comb begin
    bc_cpu_data = 32'h0;
    if (hit_dmem)      bc_cpu_data = dmem_q[dmem_idx];
    else if (hit_led)  bc_cpu_data = {16'h0, led_q};
    else if (hit_seg)  bc_cpu_data = {16'h0, segreg_q};
    else if (hit_cyc)  bc_cpu_data = cyc_rd;
    else if (hit_stat) bc_cpu_data = {31'h0, status_q};
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Bench for bus_ctrl: random and directed traffic against a byte-address-level model of the register map.
module tb_bus_ctrl;
  localparam int AW = 6;
  localparam int SD = 4;
  localparam int DMEM_BYTES = 1 << (AW + 2);
  localparam int SCAN_PERIOD = 1 << SD;
  localparam int PHASE_LEN = 1 << (SD - 2);
  localparam logic [31:0] A_LED  = 32'hFFFF_0000;
  localparam logic [31:0] A_SEG  = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC  = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_bc_addr = 32'h0;
  logic [31:0] cpu_bc_data = 32'h0;
  logic        cpu_bc_rw = 1'b0;
  logic [31:0] bc_cpu_data;
  logic [15:0] led;
  logic [7:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  bus_ctrl #(.DMEM_AW(AW), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .cpu_bc_addr(cpu_bc_addr), .cpu_bc_data(cpu_bc_data),
    .cpu_bc_rw(cpu_bc_rw), .bc_cpu_data(bc_cpu_data), .led(led), .seg(seg), .an(an)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Reference model: clock edges since reset, plus the architectural register contents.
  int          edges = 0;
  int          cyc_base = 0;
  logic [31:0] dmem_m [64];
  logic [15:0] led_m = 16'h0;
  logic [15:0] seg_m = 16'h0;
  logic        status_m = 1'b0;
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w < DMEM_BYTES) return dmem_m[w[AW+1:2]];
    case (w)
      A_LED:   return {16'h0, led_m};
      A_SEG:   return {16'h0, seg_m};
`ifdef BUS_CYCLE_CNT_EN
      A_CYC:   return 32'(edges - cyc_base);
`endif
      A_STAT:  return {31'h0, status_m};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w < DMEM_BYTES) dmem_m[w[AW+1:2]] = d;
    else begin
      case (w)
        A_LED:  led_m = d[15:0];
        A_SEG:  seg_m = d[15:0];
        A_CYC:  cyc_base = edges;
        A_STAT: if (d[0]) status_m = 1'b0;
        default: status_m = 1'b1;
      endcase
    end
  endtask

  task automatic model_reset();
    led_m = 16'h0;
    seg_m = 16'h0;
    status_m = 1'b0;
    cyc_base = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    cpu_bc_addr = a;
    cpu_bc_data = d;
    cpu_bc_rw = 1'b1;
    @(posedge clk);
    #1;
    model_wr(a, d);
    cpu_bc_rw = 1'b0;
    cpu_bc_data = $urandom;
  endtask

  task automatic goto_read(input logic [31:0] a);
    @(negedge clk);
    cpu_bc_rw = 1'b0;
    cpu_bc_addr = a;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    cpu_bc_rw = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  function automatic logic [31:0] rand_unmapped();
    logic [31:0] a;
    a = $urandom | 32'h8000_0000;
    if (a[31:4] == 28'hFFFF000) a[8] = 1'b1;
    return a;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0: return 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      1: return A_LED | 32'($urandom_range(0, 3));
      2: return A_SEG;
      3: return A_CYC;
      4: return A_STAT;
      default: return rand_unmapped();
    endcase
  endfunction

  task automatic test_reset();
    apply_reset();
    cmp_cnt++; if (led !== 16'h0) begin err_cnt++; $display("FAIL reset_led got=%h want=0000", led); end
    cmp_cnt++; if (an !== 4'b1110) begin err_cnt++; $display("FAIL reset_an got=%b want=1110", an); end
    cmp_cnt++; if (seg !== 8'hC0) begin err_cnt++; $display("FAIL reset_seg got=%h want=c0", seg); end
    cpu_bc_addr = A_STAT; #1;
    cmp_cnt++; if (bc_cpu_data !== 32'h0) begin err_cnt++; $display("FAIL reset_status got=%h want=0", bc_cpu_data); end
    cpu_bc_addr = A_CYC; #1;
    cmp_cnt++; if (bc_cpu_data !== 32'h0) begin err_cnt++; $display("FAIL reset_cyccnt got=%h want=0", bc_cpu_data); end
  endtask

  task automatic test_dmem();
    logic [31:0] a, d;
    bus_write(32'h0000_0000, 32'h0BAD_BEEF);
    bus_write(32'h0000_0010, 32'h1234_5678);
    bus_write(32'h0000_00FC, 32'hCAFE_F00D);
    goto_read(32'h0000_0010);
    cmp_cnt++; if (bc_cpu_data !== 32'h1234_5678) begin err_cnt++; $display("FAIL dmem_word4 got=%h want=12345678", bc_cpu_data); end
    goto_read(32'h0000_00FC);
    cmp_cnt++; if (bc_cpu_data !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL dmem_word63 got=%h want=cafef00d", bc_cpu_data); end
    bus_write(32'h0000_0100, 32'hDEAD_0001);
    goto_read(A_STAT);
    cmp_cnt++; if (bc_cpu_data !== 32'h1) begin err_cnt++; $display("FAIL dmem_oob_status got=%h want=1", bc_cpu_data); end
    goto_read(32'h0000_0000);
    cmp_cnt++; if (bc_cpu_data !== 32'h0BAD_BEEF) begin err_cnt++; $display("FAIL dmem_oob_word0 got=%h want=0badbeef", bc_cpu_data); end
    for (int i = 0; i < 64; i++) bus_write(32'(i * 4), $urandom);
    for (int i = 0; i < 20; i++) begin
      a = 32'($urandom_range(0, 63) * 4);
      d = $urandom;
      bus_write(a | 32'($urandom_range(0, 3)), d);
      goto_read(a | 32'($urandom_range(0, 3)));
      cmp_cnt++; if (bc_cpu_data !== exp_read(a)) begin err_cnt++; $display("FAIL dmem_rand a=%h got=%h want=%h", a, bc_cpu_data, exp_read(a)); end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? A_LED : 32'($urandom_range(0, 63) * 4);
      @(negedge clk);
      cpu_bc_addr = a;
      cpu_bc_data = $urandom;
      cpu_bc_rw = 1'b1;
      #1;
      cmp_cnt++; if (bc_cpu_data !== exp_read(a)) begin err_cnt++; $display("FAIL raw_old a=%h got=%h want=%h", a, bc_cpu_data, exp_read(a)); end
      @(posedge clk);
      #1;
      model_wr(a, cpu_bc_data);
      cpu_bc_rw = 1'b0;
      #1;
      cmp_cnt++; if (bc_cpu_data !== exp_read(a)) begin err_cnt++; $display("FAIL raw_new a=%h got=%h want=%h", a, bc_cpu_data, exp_read(a)); end
    end
  endtask

  task automatic test_led_seg();
    int ph;
    logic [15:0] nib;
    logic [3:0] exp_an;
    bus_write(A_LED, 32'h0000_A5A5);
    cmp_cnt++; if (led !== 16'hA5A5) begin err_cnt++; $display("FAIL led_a5a5 got=%h want=a5a5", led); end
    for (int r = 0; r < 3; r++) begin
      bus_write(A_SEG, (r == 0) ? 32'h0000_3F1C : $urandom);
      for (int i = 0; i < SCAN_PERIOD; i++) begin
        @(posedge clk); #2;
        ph = ((edges - 1) % SCAN_PERIOD) / PHASE_LEN;
        exp_an = ~(4'b0001 << ph);
        nib = seg_m >> (4 * ph);
        cmp_cnt++; if (an !== exp_an) begin err_cnt++; $display("FAIL scan_an ph=%0d got=%b want=%b", ph, an, exp_an); end
        cmp_cnt++; if (seg !== hex_tab[nib[3:0]]) begin err_cnt++; $display("FAIL scan_seg ph=%0d got=%h want=%h", ph, seg, hex_tab[nib[3:0]]); end
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] a;
    bus_write(A_STAT, 32'h1);
    goto_read(32'h8000_0000);
    cmp_cnt++; if (bc_cpu_data !== 32'h0) begin err_cnt++; $display("FAIL unmapped_rd got=%h want=0", bc_cpu_data); end
    for (int i = 0; i < 6; i++) begin
      a = rand_unmapped();
      goto_read(a);
      cmp_cnt++; if (bc_cpu_data !== 32'h0) begin err_cnt++; $display("FAIL unmapped_rand_rd a=%h got=%h want=0", a, bc_cpu_data); end
    end
    goto_read(A_STAT);
    cmp_cnt++; if (bc_cpu_data !== 32'h0) begin err_cnt++; $display("FAIL status_clear got=%h want=0", bc_cpu_data); end
    bus_write(32'h8000_0000, $urandom);
    goto_read(A_STAT);
    cmp_cnt++; if (bc_cpu_data !== 32'h1) begin err_cnt++; $display("FAIL status_set got=%h want=1", bc_cpu_data); end
    cmp_cnt++; if (led !== led_m) begin err_cnt++; $display("FAIL unmapped_led got=%h want=%h", led, led_m); end
    bus_write(A_STAT, 32'hFFFF_FFFE);
    goto_read(A_STAT);
    cmp_cnt++; if (bc_cpu_data !== 32'h1) begin err_cnt++; $display("FAIL status_w0 got=%h want=1", bc_cpu_data); end
    bus_write(A_STAT, 32'h1);
    cmp_cnt++; if (bc_cpu_data !== 32'h0) begin err_cnt++; $display("FAIL status_w1c got=%h want=0", bc_cpu_data); end
  endtask

  task automatic test_cyccnt();
`ifdef BUS_CYCLE_CNT_EN
    logic [31:0] c10, c20;
    apply_reset();
    for (int g = 0; g < 100 && edges < 10; g++) @(negedge clk);
    cpu_bc_addr = A_CYC; #1;
    c10 = bc_cpu_data;
    cmp_cnt++; if (c10 !== 32'd10) begin err_cnt++; $display("FAIL cyc_at10 got=%0d want=10", c10); end
    for (int g = 0; g < 100 && edges < 20; g++) @(negedge clk);
    #1;
    c20 = bc_cpu_data;
    cmp_cnt++; if (c20 - c10 !== 32'd10) begin err_cnt++; $display("FAIL cyc_diff got=%0d want=10", c20 - c10); end
    bus_write(A_CYC, $urandom);
    goto_read(A_CYC);
    cmp_cnt++; if (bc_cpu_data !== 32'd0) begin err_cnt++; $display("FAIL cyc_clr0 got=%0d want=0", bc_cpu_data); end
    goto_read(A_CYC);
    cmp_cnt++; if (bc_cpu_data !== 32'd1) begin err_cnt++; $display("FAIL cyc_clr1 got=%0d want=1", bc_cpu_data); end
`else
    for (int i = 0; i < 4; i++) begin
      goto_read(A_CYC);
      cmp_cnt++; if (bc_cpu_data !== 32'h0) begin err_cnt++; $display("FAIL cyc_off_rd got=%h want=0", bc_cpu_data); end
    end
    bus_write(A_STAT, 32'h1);
    bus_write(A_CYC, $urandom);
    goto_read(A_STAT);
    cmp_cnt++; if (bc_cpu_data !== 32'h0) begin err_cnt++; $display("FAIL cyc_off_noflag got=%h want=0", bc_cpu_data); end
`endif
  endtask

  task automatic test_random_traffic();
    logic [31:0] a, d;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = rand_addr();
        d = $urandom;
        bus_write(a, d);
      end
      a = rand_addr();
      goto_read(a);
      cmp_cnt++; if (bc_cpu_data !== exp_read(a)) begin err_cnt++; $display("FAIL rand_rd a=%h got=%h want=%h", a, bc_cpu_data, exp_read(a)); end
      cmp_cnt++; if (led !== led_m) begin err_cnt++; $display("FAIL rand_led got=%h want=%h", led, led_m); end
    end
  endtask

  task automatic test_midop_reset();
    bit found;
    bus_write(32'h0000_0020, 32'h5A5A_0001);
    bus_write(A_LED, 32'h0000_FFFF);
    found = 1'b0;
    for (int g = 0; g < 4 * SCAN_PERIOD && !found; g++) begin
      @(posedge clk); #2;
      if (((edges - 1) % SCAN_PERIOD) / PHASE_LEN == 2) found = 1'b1;
    end
    cmp_cnt++; if (!found || an !== 4'b1011) begin err_cnt++; $display("FAIL midop_digit2 got=%b want=1011", an); end
    rst = 1'b1;
    #1;
    cmp_cnt++; if (led !== 16'h0) begin err_cnt++; $display("FAIL midop_led got=%h want=0000", led); end
    cmp_cnt++; if (an !== 4'b1110) begin err_cnt++; $display("FAIL midop_an got=%b want=1110", an); end
    cmp_cnt++; if (seg !== 8'hC0) begin err_cnt++; $display("FAIL midop_seg got=%h want=c0", seg); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    goto_read(32'h0000_0020);
    cmp_cnt++; if (bc_cpu_data !== 32'h5A5A_0001) begin err_cnt++; $display("FAIL midop_dmem got=%h want=5a5a0001", bc_cpu_data); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dmem();
    test_same_cycle();
    test_led_seg();
    test_unmapped();
    test_cyccnt();
    test_random_traffic();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
